uart_rx_packer: RTL and testbench

UART_RX_PACKER -- requirements
Module: uart_rx_packer

---
 rtl/uart_rx_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packer.sv
// UART receiver (8N1, or 8E1 when RX_PARITY_EN is defined) that packs two bytes into a 16-bit word
// with a valid/ready handshake. The first byte lands in [7:0] and the second in [15:8].
module uart_rx_packer #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RXD,
    output logic [15:0] WORD_DATA,
    output logic        WORD_VALID,
    input  logic        WORD_READY,
    output logic        FRAME_ERR,
    output logic        OVERRUN,
    output logic        BUSY
);

    localparam int unsigned CntW = 12;
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e state_q, state_d;

    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            phase_q, phase_d;
    logic [7:0]      low_q, low_d;
    logic [15:0]     word_data_q, word_data_d;
    logic            word_valid_q, word_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic fall_edge;
    logic sample_tick;
    logic byte_ok;
    logic byte_err;
    logic handshake;

`ifdef RX_PARITY_EN
    logic parity_bad_q, parity_bad_d;
`endif

    // Falling edge is seen only on the synchronized line, one flop behind it.
    assign fall_edge   = rxd_prev_q & ~rxd_sync_q;
    assign sample_tick = (state_q == StStart) ? (cnt_q == HalfBit) : (cnt_q == LastCnt);
    assign handshake   = word_valid_q & WORD_READY;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (fall_edge) state_d = StStart;
            end
            StStart: begin
                if (sample_tick) state_d = rxd_sync_q ? StIdle : StData;
            end
            StData: begin
                if (sample_tick && (bit_idx_q == 3'd7)) begin
`ifdef RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef RX_PARITY_EN
            StParity: begin
                if (sample_tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (sample_tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Receiver datapath and byte-level outputs.
    always_comb begin
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_ok     = 1'b0;
        byte_err    = 1'b0;
`ifdef RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        if (state_q == StIdle) begin
            cnt_d     = '0;
            bit_idx_d = '0;
        end else if (sample_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        case (state_q)
            StStart: begin
`ifdef RX_PARITY_EN
                parity_bad_d = 1'b0;
`endif
            end
            StData: begin
                if (sample_tick) begin
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
`ifdef RX_PARITY_EN
            StParity: begin
                if (sample_tick && ((^shift_q) != rxd_sync_q)) begin
                    parity_bad_d = 1'b1;
                    byte_err     = 1'b1;
                end
            end
            StStop: begin
                if (sample_tick) begin
                    byte_ok  = rxd_sync_q & ~parity_bad_q;
                    byte_err = ~rxd_sync_q;
                end
            end
`else
            StStop: begin
                if (sample_tick) begin
                    byte_ok  = rxd_sync_q;
                    byte_err = ~rxd_sync_q;
                end
            end
`endif
            default: ;
        endcase
        frame_err_d = byte_err;
    end

    // Packer and word handshake; a word finishing during a handshake replaces the old one.
    always_comb begin
        phase_d      = phase_q;
        low_d        = low_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        overrun_d    = 1'b0;
        if (handshake) word_valid_d = 1'b0;
        if (byte_err) begin
            phase_d = 1'b0;
        end else if (byte_ok) begin
            if (!phase_q) begin
                low_d   = shift_q;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (!word_valid_q || handshake) begin
                    word_data_d  = {shift_q, low_q};
                    word_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rxd_prev_q   <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            phase_q      <= 1'b0;
            low_q        <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q   <= RXD;
            rxd_sync_q   <= rxd_meta_q;
            rxd_prev_q   <= rxd_sync_q;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            phase_q      <= phase_d;
            low_q        <= low_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    // Output logic.
    always_comb begin
        WORD_DATA  = word_data_q;
        WORD_VALID = word_valid_q;
        FRAME_ERR  = frame_err_q;
        OVERRUN    = overrun_q;
        BUSY       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer at CLKS_PER_BIT=4: stimulus queues expected words, a monitor
// pops them on each handshake. Parity cases run only when RX_PARITY_EN is defined.
module tb_uart_rx_packer;

    localparam int unsigned Cpb = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RXD;
    logic        WORD_READY;
    logic [15:0] WORD_DATA;
    logic        WORD_VALID;
    logic        FRAME_ERR;
    logic        OVERRUN;
    logic        BUSY;

    int          total = 0;
    int          bad = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          fe0;
    int          ov0;
    logic [15:0] exp_q[$];
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = '0;

    always #5 CLK = ~CLK;

    uart_rx_packer #(.CLKS_PER_BIT(Cpb)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RXD       (RXD),
        .WORD_DATA (WORD_DATA),
        .WORD_VALID(WORD_VALID),
        .WORD_READY(WORD_READY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .BUSY      (BUSY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        RXD = b;
        repeat (Cpb) tick();
    endtask

    // Same 4-cycle bit, with a 1-cycle RESET pulse in its middle and a reset-value check.
    task automatic send_bit_rst(input logic b);
        RXD = b;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_mid_valid", 32'(WORD_VALID), 32'd0);
        chk("rst_mid_data", 32'(WORD_DATA), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_ferr", 32'(FRAME_ERR), 32'd0);
        chk("rst_mid_ovr", 32'(OVERRUN), 32'd0);
        tick();
        tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int rst_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) send_bit_rst(data[i]);
            else send_bit(data[i]);
        end
`ifdef RX_PARITY_EN
        send_bit(^data);
`endif
        send_bit(stop_bit);
    endtask

    task automatic send_byte(input logic [7:0] data);
        send_frame(data, 1'b1, -1);
        idle(2 * Cpb);
    endtask

`ifdef RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] data, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(par);
        send_bit(1'b1);
        idle(2 * Cpb);
    endtask
`endif

    // Monitor: pops the scoreboard on handshakes, checks holding, counts error pulses.
    always @(negedge CLK) begin
        if (RESET) begin
            prev_hold = 1'b0;
        end else begin
            if (FRAME_ERR) fe_cnt++;
            if (OVERRUN) ov_cnt++;
            if (prev_hold) begin
                chk("hold_valid", 32'(WORD_VALID), 32'd1);
                chk("hold_data", 32'(WORD_DATA), 32'(prev_data));
            end
            if (WORD_VALID && WORD_READY) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word_unexpected: got 0x%0h want none", WORD_DATA);
                end else begin
                    chk("word", 32'(WORD_DATA), 32'(exp_q.pop_front()));
                end
            end
            prev_hold = WORD_VALID && !WORD_READY;
            prev_data = WORD_DATA;
        end
    end

    initial begin
        RESET      = 1'b1;
        RXD        = 1'b1;
        WORD_READY = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_valid", 32'(WORD_VALID), 32'd0);
        chk("rst_data", 32'(WORD_DATA), 32'd0);
        chk("rst_ferr", 32'(FRAME_ERR), 32'd0);
        chk("rst_ovr", 32'(OVERRUN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        idle(2 * Cpb);

        // Basic word and its exact latency after the second stop sample.
        exp_q.push_back(16'h1234);
        send_byte(8'h34);
        send_frame(8'h12, 1'b1, -1);
        @(negedge CLK);
        @(negedge CLK);
        chk("lat_before", 32'(WORD_VALID), 32'd0);
        @(negedge CLK);
        chk("lat_valid", 32'(WORD_VALID), 32'd1);
        chk("lat_data", 32'(WORD_DATA), 32'h1234);
        @(negedge CLK);
        chk("lat_pulse_1cyc", 32'(WORD_VALID), 32'd0);
        idle(2 * Cpb);

        // Overrun: held word survives a dropped second word.
        WORD_READY = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(16'h55AA);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge CLK);
        chk("ovr_count", 32'(ov_cnt - ov0), 32'd1);
        chk("ovr_valid", 32'(WORD_VALID), 32'd1);
        chk("ovr_data", 32'(WORD_DATA), 32'h55AA);
        tick();
        WORD_READY = 1'b1;
        tick();
        @(negedge CLK);
        chk("ovr_valid_fall", 32'(WORD_VALID), 32'd0);
        idle(2 * Cpb);

        // New word completing in the handshake cycle: loads, no overrun.
        WORD_READY = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(16'h2211);
        send_byte(8'h11);
        send_byte(8'h22);
        exp_q.push_back(16'h4433);
        send_byte(8'h33);
        send_frame(8'h44, 1'b1, -1);
        tick();
        WORD_READY = 1'b1;
        tick();
        WORD_READY = 1'b0;
        @(negedge CLK);
        chk("same_cyc_valid", 32'(WORD_VALID), 32'd1);
        chk("same_cyc_data", 32'(WORD_DATA), 32'h4433);
        chk("same_cyc_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        idle(Cpb);
        WORD_READY = 1'b1;
        idle(2 * Cpb);

        // Framing error then a clean word; also a stored low byte must be discarded.
        fe0 = fe_cnt;
        send_frame(8'h34, 1'b0, -1);
        idle(2 * Cpb);
        chk("ferr_count", 32'(fe_cnt - fe0), 32'd1);
        exp_q.push_back(16'h5678);
        send_byte(8'h78);
        send_byte(8'h56);
        fe0 = fe_cnt;
        send_byte(8'h99);
        send_frame(8'h34, 1'b0, -1);
        idle(2 * Cpb);
        chk("ferr_count2", 32'(fe_cnt - fe0), 32'd1);
        exp_q.push_back(16'hBCDE);
        send_byte(8'hDE);
        send_byte(8'hBC);

        // One-cycle glitch: receiver goes busy, then back to idle without error.
        fe0 = fe_cnt;
        RXD = 1'b0;
        tick();
        RXD = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        chk("glitch_busy", 32'(BUSY), 32'd1);
        repeat (8) tick();
        @(negedge CLK);
        chk("glitch_idle", 32'(BUSY), 32'd0);
        chk("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd0);
        idle(Cpb);
        exp_q.push_back(16'h4321);
        send_byte(8'h21);
        send_byte(8'h43);

        // Reset during bit 3 of the second byte; remaining bits of 0xF8 are high.
        send_byte(8'h11);
        send_frame(8'hF8, 1'b1, 3);
        idle(2 * Cpb);
        exp_q.push_back(16'hABCD);
        send_byte(8'hCD);
        send_byte(8'hAB);

`ifdef RX_PARITY_EN
        fe0 = fe_cnt;
        send_frame_par(8'h03, 1'b1);
        chk("par_bad_ferr", 32'(fe_cnt - fe0), 32'd1);
        exp_q.push_back(16'h0403);
        send_frame_par(8'h03, 1'b0);
        send_byte(8'h04);
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
